// File: rtl/fpll_avmm_rmw_sequencer_if.sv
// fpll_avmm_rmw_sequencer_if: host command/response and fPLL Avalon-MM reconfiguration signals
interface fpll_avmm_rmw_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [8:0] cmd_addr;
  logic [7:0] cmd_mask;
  logic [7:0] cmd_data;
  logic       cmd_wait_lock;
  logic       rsp_valid;
  logic [1:0] rsp_error;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic [8:0] pll_avmmaddress;
  logic       pll_avmmread;
  logic       pll_avmmwrite;
  logic [7:0] pll_avmmwritedata;
  logic [7:0] pll_avmmreaddata;
  logic       pll_lock;
  modport master (
    input  cmd_valid, cmd_addr, cmd_mask, cmd_data, cmd_wait_lock, pll_avmmreaddata, pll_lock,
    output cmd_ready, rsp_valid, rsp_error, rsp_rdata, busy,
           pll_avmmaddress, pll_avmmread, pll_avmmwrite, pll_avmmwritedata
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_mask, cmd_data, cmd_wait_lock, pll_avmmreaddata, pll_lock,
    input  cmd_ready, rsp_valid, rsp_error, rsp_rdata, busy,
           pll_avmmaddress, pll_avmmread, pll_avmmwrite, pll_avmmwritedata
  );
endinterface

// File: rtl/fpll_avmm_rmw_sequencer.sv
// fpll_avmm_rmw_sequencer: masked read-modify-write of one fPLL register with optional re-lock wait; FPLL_RMW_VERIFY_EN adds a readback verify
module fpll_avmm_rmw_sequencer #(
  parameter int READ_LATENCY = 2,
  parameter int LOCK_BLANK   = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int CNT_W        = 13
) (
  input logic avmmclk,
  input logic avmmrstn,
  fpll_avmm_rmw_sequencer_if.master bus
);
`ifdef FPLL_RMW_VERIFY_EN
  typedef enum logic [2:0] {IDLE, READ, RWAIT, WRITE, LOCK_WAIT, DONE, VERIFY, VWAIT} state_t;
  localparam state_t POST = VERIFY;
`else
  typedef enum logic [2:0] {IDLE, READ, RWAIT, WRITE, LOCK_WAIT, DONE} state_t;
  localparam state_t POST = DONE;
`endif
  state_t st, nxt;
  logic [CNT_W-1:0] cnt;
  logic [8:0] addr_q;
  logic [7:0] mask_q, data_q, rd_q;
  logic wl_q;
  logic [1:0] err;
  logic rd_done, lk_ok, lk_to;
  assign rd_done = cnt == CNT_W'(READ_LATENCY - 1);
  assign lk_ok = cnt >= CNT_W'(LOCK_BLANK) && bus.pll_lock;
  // timeout lands so the response comes LOCK_BLANK+LOCK_TIMEOUT cycles after the write strobe
  assign lk_to = cnt == CNT_W'(LOCK_BLANK + LOCK_TIMEOUT - 2);
  assign bus.cmd_ready = st == IDLE;
  assign bus.busy = st != IDLE;
  assign bus.rsp_valid = st == DONE;
  assign bus.rsp_rdata = st == DONE ? rd_q : '0;
  assign bus.rsp_error = st == DONE ? err : '0;
  assign bus.pll_avmmaddress = st != IDLE ? addr_q : '0;
`ifdef FPLL_RMW_VERIFY_EN
  assign bus.pll_avmmread = st == READ || st == VERIFY;
`else
  assign bus.pll_avmmread = st == READ;
`endif
  assign bus.pll_avmmwrite = st == WRITE;
  assign bus.pll_avmmwritedata = st == WRITE ? (rd_q & ~mask_q) | (data_q & mask_q) : '0;
  // next-state decode; lock success beats a timeout expiring in the same cycle
  always_comb begin
    nxt = st;
    case (st)
      IDLE:      nxt = bus.cmd_valid ? READ : IDLE;
      READ:      nxt = RWAIT;
      RWAIT:     nxt = !rd_done ? RWAIT : mask_q == '0 ? DONE : WRITE;
      WRITE:     nxt = wl_q ? LOCK_WAIT : POST;
      LOCK_WAIT: nxt = lk_ok ? POST : lk_to ? DONE : LOCK_WAIT;
`ifdef FPLL_RMW_VERIFY_EN
      VERIFY:    nxt = VWAIT;
      VWAIT:     nxt = rd_done ? DONE : VWAIT;
`endif
      DONE:      nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end
  // state, per-state cycle counter (cleared on every state change), command capture and status
  always_ff @(posedge avmmclk) begin
    if (!avmmrstn) begin
      st <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      mask_q <= '0;
      data_q <= '0;
      wl_q <= 1'b0;
      rd_q <= '0;
      err <= '0;
    end else begin
      st <= nxt;
      cnt <= nxt != st ? '0 : cnt + CNT_W'(1);
      if (st == IDLE && bus.cmd_valid) begin
        addr_q <= bus.cmd_addr;
        mask_q <= bus.cmd_mask;
        data_q <= bus.cmd_data;
        wl_q <= bus.cmd_wait_lock;
        err <= '0;
      end
      if (st == RWAIT && rd_done) rd_q <= bus.pll_avmmreaddata;
      if (st == LOCK_WAIT && !lk_ok && lk_to) err <= 2'b01;
`ifdef FPLL_RMW_VERIFY_EN
      if (st == VWAIT && rd_done && |((bus.pll_avmmreaddata ^ data_q) & mask_q)) err <= 2'b10;
`endif
    end
  end
endmodule

// File: tb/tb_fpll_avmm_rmw_sequencer.sv
// tb_fpll_avmm_rmw_sequencer: randomized scoreboard bench with an fPLL register-file/lock model
module tb_fpll_avmm_rmw_sequencer;
  localparam int RL = 2, BLANK = 16, TO = 4096;
  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;
  fpll_avmm_rmw_sequencer_if bus();
  fpll_avmm_rmw_sequencer #(.READ_LATENCY(RL), .LOCK_BLANK(BLANK), .LOCK_TIMEOUT(TO), .CNT_W(13))
    dut (.avmmclk(clk), .avmmrstn(rstn), .bus(bus));

  typedef struct {
    logic [8:0] addr;
    logic [7:0] rdata;
    logic [1:0] err;
    int         lat;
    int         nwr;
    logic [7:0] wdata;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  int cyc = 0, acc = 0, nw = 0;
  int lock_at = 0, wk = 1 << 30;
  logic [7:0] corrupt = '0;
  logic [7:0] mem [512];
  logic seeded = 1'b0;
  logic poke_en = 1'b0;
  logic [8:0] poke_a = '0;
  logic [7:0] poke_d = '0;
  logic [7:0] pd [RL];
  int nreads = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // fPLL model: register file, read pipeline of RL stages (garbage when no read), writes, pokes
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'(i * 37 + 5);
      seeded <= 1'b1;
    end
    if (poke_en) mem[poke_a] <= poke_d;
    if (bus.pll_avmmwrite) mem[bus.pll_avmmaddress] <= bus.pll_avmmwritedata;
    pd[0] <= bus.pll_avmmread ? mem[bus.pll_avmmaddress] ^ (nreads == 1 ? corrupt : 8'h00) : 8'($urandom);
    for (int i = 1; i < RL; i++) pd[i] <= pd[i-1];
    if (bus.cmd_valid && bus.cmd_ready) nreads <= 0;
    else if (bus.pll_avmmread) nreads <= nreads + 1;
  end
  assign bus.pll_avmmreaddata = pd[RL-1];

  // lock model: high from lock_at cycles after the write strobe onward
  always @(negedge clk) begin
    wk = bus.pll_avmmwrite ? 0 : wk + 1;
    bus.pll_lock = wk >= lock_at;
  end

  // monitor: checks strobes and responses against the scoreboard head
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rstn) nw = 0;
    else begin
      if (bus.pll_avmmread) begin
        if (q.size() == 0) chk("read_unexpected", 1, 0);
        else chk("read_addr", {23'd0, bus.pll_avmmaddress}, {23'd0, q[0].addr});
      end
      if (bus.pll_avmmwrite) begin
        nw++;
        if (q.size() == 0) chk("write_unexpected", 1, 0);
        else begin
          chk("wdata", {24'd0, bus.pll_avmmwritedata}, {24'd0, q[0].wdata});
          chk("write_cycle", cyc - acc + 1, RL + 2);
          chk("strobe_excl", {31'd0, bus.pll_avmmread}, 0);
        end
      end
      if (bus.rsp_valid) begin
        if (q.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          e = q.pop_front();
          chk("rsp_rdata", {24'd0, bus.rsp_rdata}, {24'd0, e.rdata});
          chk("rsp_error", {30'd0, bus.rsp_error}, {30'd0, e.err});
          chk("rsp_latency", cyc - acc + 1, e.lat);
          chk("write_count", nw, e.nwr);
        end
        nw = 0;
      end
    end
  end

  // reference model from the command rules, then drive and wait for acceptance
  task automatic issue(input logic [8:0] a, input logic [7:0] m, input logic [7:0] d,
                       input logic wl, input int lk, input logic [7:0] corr);
    exp_t e;
    int t = 0, x = 0, s;
    logic ver = 1'b1;
    @(negedge clk);
    while (!bus.cmd_ready && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (!bus.cmd_ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    e.addr = a;
    e.rdata = mem[a];
    e.wdata = (mem[a] & ~m) | (d & m);
    e.err = 2'b00;
    e.nwr = m != 0 ? 1 : 0;
    if (m == 0) e.lat = RL + 2;
    else begin
      if (wl) begin
        s = lk > BLANK + 1 ? lk : BLANK + 1;
        if (s <= BLANK + TO - 1) x = s;
        else begin
          x = BLANK + TO - 1;
          e.err = 2'b01;
          ver = 1'b0;
        end
      end
`ifdef FPLL_RMW_VERIFY_EN
      if (ver) begin
        x += RL + 1;
        if ((corr & m) != 0) e.err = 2'b10;
      end
`endif
      e.lat = RL + 3 + x;
    end
    lock_at = lk;
    corrupt = corr;
    q.push_back(e);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr = a;
    bus.cmd_mask = m;
    bus.cmd_data = d;
    bus.cmd_wait_lock = wl;
    @(posedge clk);
    #1;
    acc = cyc;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr = 9'($urandom);
    bus.cmd_mask = 8'($urandom);
    bus.cmd_data = 8'($urandom);
    bus.cmd_wait_lock = 1'($urandom);
  endtask

  task automatic poke(input logic [8:0] a, input logic [7:0] d);
    @(negedge clk);
    while (!bus.cmd_ready) @(negedge clk);
    poke_en = 1'b1;
    poke_a = a;
    poke_d = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, {31'd0, bus.cmd_ready}, 1);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 0);
    chk({tag, "_strobes"}, {30'd0, bus.pll_avmmread, bus.pll_avmmwrite}, 0);
    chk({tag, "_rsp"}, {31'd0, bus.rsp_valid}, 0);
    chk({tag, "_addr"}, {23'd0, bus.pll_avmmaddress}, 0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_mask = '0;
    bus.cmd_data = '0;
    bus.cmd_wait_lock = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rstn = 1'b1;
    @(negedge clk);
    check_idle("post_reset");
    poke(9'h1A5, 8'hC9);
    issue(9'h1A5, 8'h0F, 8'h03, 1'b0, 0, 8'h00);
    issue(9'h0A0, 8'h00, 8'h5A, 1'b0, 0, 8'h00);
    issue(9'h033, 8'hF0, 8'hA5, 1'b1, 0, 8'h00);
    issue(9'h044, 8'h81, 8'hFF, 1'b1, 32'h7fffffff, 8'h00);
    issue(9'h045, 8'h3C, 8'h00, 1'b1, BLANK + TO - 1, 8'h00);
    issue(9'h046, 8'hC3, 8'h55, 1'b1, BLANK + TO, 8'h00);
    issue(9'h100, 8'hFF, 8'h12, 1'b0, 0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    check_idle("abort");
    @(negedge clk);
    rstn = 1'b1;
    repeat (RL + 4) @(negedge clk);
    chk("abort_no_write", {23'd0, mem[9'h100]}, {23'd0, 8'(9'h100 * 37 + 5)});
    issue(9'h100, 8'hFF, 8'h12, 1'b0, 0, 8'h00);
`ifdef FPLL_RMW_VERIFY_EN
    issue(9'h050, 8'h0F, 8'h06, 1'b0, 0, 8'h01);
    issue(9'h051, 8'h0F, 8'h06, 1'b0, 0, 8'h80);
    issue(9'h052, 8'hF0, 8'h90, 1'b1, 5, 8'h10);
`endif
    for (int i = 0; i < 40; i++) begin
      logic [7:0] m;
      logic [7:0] c;
      m = $urandom_range(0, 3) == 0 ? 8'h00 : 8'($urandom);
      c = '0;
`ifdef FPLL_RMW_VERIFY_EN
      c = $urandom_range(0, 1) == 0 ? 8'h00 : 8'($urandom);
`endif
      issue(9'($urandom), m, 8'($urandom), 1'($urandom_range(0, 2) == 0),
            $urandom_range(0, 1) == 0 ? 0 : int'($urandom_range(1, 40)), c);
    end
    for (int i = 0; i < 20000 && q.size() != 0; i++) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpll_avmm_rmw_sequencer.md
Name: fpll_avmm_rmw_sequencer

Overview:
- Upstream Avalon-MM reconfiguration master for the fPLL wrapper.
- Drives its avmmaddress/avmmread/avmmwrite/avmmwritedata and samples avmmreaddata and lock.
- Turns one host command into a masked read-modify-write of one 8-bit fPLL register, for example a counter, bandwidth or refclk-select field.
- Can optionally wait for PLL re-lock, then returns a single-cycle status response.

Parameters:
- READ_LATENCY, 2: cycles from the read strobe to valid avmmreaddata (1..7).
- LOCK_BLANK, 16: cycles after the write during which lock is ignored.
- LOCK_TIMEOUT, 4096: maximum cycles in LOCK_WAIT, counted after blanking.
- CNT_W, 13: width of the lock-wait counter; must satisfy 2^CNT_W > LOCK_TIMEOUT.

Ports:
- avmmclk, input, 1: the single clock.
- avmmrstn, input, 1: synchronous, active-low reset.
- cmd_valid, input, 1: command request.
- cmd_ready, output, 1: high only in IDLE.
- cmd_addr, input, 9: fPLL register address.
- cmd_mask, input, 8: bits to modify; 0 means read-only.
- cmd_data, input, 8: new values for the masked bits.
- cmd_wait_lock, input, 1: wait for re-lock after the write.
- rsp_valid, output, 1: one-cycle response pulse.
- rsp_error, output, 2: 00 ok, 01 lock timeout, 10 verify mismatch.
- rsp_rdata, output, 8: original register value that was read.
- busy, output, 1: high whenever state is not IDLE.
- pll_avmmaddress, output, 9: to fPLL avmmaddress.
- pll_avmmread, output, 1: to fPLL avmmread.
- pll_avmmwrite, output, 1: to fPLL avmmwrite.
- pll_avmmwritedata, output, 8: to fPLL avmmwritedata.
- pll_avmmreaddata, input, 8: from fPLL avmmreaddata.
- pll_lock, input, 1: from fPLL lock.

Behaviour:
- Reset (avmmrstn low at a rising edge of avmmclk):
  - State goes to IDLE.
  - All outputs go to 0, except cmd_ready, which is 1.
  - Reset mid-operation aborts the operation: strobes drop on the next edge and no response is issued.
- Command acceptance:
  - A command is accepted when cmd_valid && cmd_ready.
  - addr, mask, data and wait_lock are registered at acceptance.
  - Inputs are ignored while busy.
- State machine:
  - IDLE -> READ on acceptance.
  - READ: pll_avmmread=1 and pll_avmmaddress=addr for exactly 1 cycle -> RWAIT.
  - RWAIT: counts READ_LATENCY cycles. pll_avmmreaddata is captured into rd_q at the edge ending cycle T+READ_LATENCY, where T is the READ cycle. Then:
    - to DONE if mask==0;
    - otherwise to WRITE.
  - WRITE: pll_avmmwrite=1 for 1 cycle.
    - pll_avmmwritedata = (rd_q & ~mask) | (data & mask).
    - Next state: LOCK_WAIT if wait_lock, else VERIFY (macro defined) or DONE (macro undefined).
  - LOCK_WAIT:
    - Counter cleared on entry.
    - pll_lock is ignored for the first LOCK_BLANK cycles.
    - Thereafter, pll_lock=1 gives success.
    - If LOCK_TIMEOUT post-blank cycles elapse with lock low, set err=01 and go to DONE.
    - Lock asserting in the same cycle the timeout expires counts as success.
    - On success the next state is VERIFY (macro defined) or DONE.
  - DONE: rsp_valid=1 for 1 cycle with rsp_rdata=rd_q and rsp_error=err -> IDLE.
- pll_avmmaddress holds addr from READ through DONE and returns to 0 in IDLE.
- Strobes are never asserted together, and never for more than one cycle per access.
- Latency from the acceptance edge to rsp_valid:
  - READ_LATENCY+3 cycles with mask≠0 and no lock wait or verify;
  - READ_LATENCY+2 cycles with mask==0.
- Back-to-back operation: cmd_ready rises in the cycle after rsp_valid, so there is a minimum of one idle cycle between commands.
- There is no backpressure on responses.

Optional Feature:
- Macro: FPLL_RMW_VERIFY_EN.
- When defined, a VERIFY/VWAIT pair is added after WRITE, or after a successful LOCK_WAIT:
  - a second single-cycle read to the same address;
  - a wait of READ_LATENCY cycles;
  - comparison of (readback & mask) against (data & mask).
- A mismatch sets err=10; a lock-timeout code takes precedence and VERIFY is skipped on timeout.
- This adds READ_LATENCY+1 cycles of latency.
- When undefined, no verify states exist and rsp_error[1] is constant 0.

Test Plan:
- Reset release with READ_LATENCY=2 → cmd_ready=1, all strobes 0.
- Command addr=0x1A5, mask=0x0F, data=0x03, wait_lock=0, readdata=0xC9:
  - read strobe at cycle 1, write strobe at cycle 4;
  - writedata=0xC3;
  - rsp_valid at cycle 5 with rdata=0xC9, error=00.
- Command with mask=0x00 → no write strobe; rsp_valid at cycle 4 with rdata equal to the read value.
- wait_lock=1, LOCK_BLANK=16, lock held 1 throughout → rsp arrives at least 16 cycles after the write, error=00.
- wait_lock=1 with lock stuck at 0 → rsp error=01 exactly 16+4096 cycles after the write.
- avmmrstn low during RWAIT → on the next edge busy=0, no write strobe, no rsp_valid; a subsequent command completes normally.
- With FPLL_RMW_VERIFY_EN, readback corrupted in the masked bits → error=10.
